nios_system_sram_arbiter: RTL and testbench

- Shares one external asynchronous SRAM (11-bit address, 16-bit data) between the Nios CPU and one hardware requester.
- The CPU side is an Avalon-MM register slave in the same 4-word PIO style as the SRAM address port.
- The hardware side is a request/grant handshake.
- A round-robin arbiter grants one requester at a time; a fixed-timing FSM then sequences SRAM address, chip-enable, output-enable, write-enable and data.

---
 rtl/nios_system_sram_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_nios_system_sram_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_sram_arbiter.sv
// nios_system_sram_arbiter
//   Shares one asynchronous SRAM between the Nios CPU (Avalon-MM register
//   slave) and one hardware requester (req/gnt handshake). A round-robin
//   arbiter picks an owner while idle. A fixed-timing sequencer then runs
//   SETUP -> ACCESS x (WAIT_CYCLES+1) -> RECOVER.
//
// Ports
//   clk, reset_n           : clock, synchronous active-low reset
//   address..readdata      : Avalon-MM slave, 4 registers
//                            (ADDR, WDATA, CTRL/STATUS, RDATA)
//   hw_req..hw_rdata       : hardware requester handshake
//                            (gnt and done are 1-cycle pulses)
//   sram_*                 : SRAM address, data, drive enable and
//                            active-low strobes
module nios_system_sram_arbiter #(
  parameter int ADDR_W      = 11,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  input  logic              hw_req,
  input  logic              hw_we,
  input  logic [ADDR_W-1:0] hw_addr,
  input  logic [DATA_W-1:0] hw_wdata,
  output logic              hw_gnt,
  output logic              hw_done,
  output logic [DATA_W-1:0] hw_rdata,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  input  logic [DATA_W-1:0] sram_dq_in,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETUP   = 2'd1,
    S_ACCESS  = 2'd2,
    S_RECOVER = 2'd3
  } state_e;

  localparam logic [2:0] LAST_CNT = 3'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [2:0]          cnt_q, cnt_d;

  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                cpu_pending_q;
  logic                cpu_we_q;
  logic                done_q;
  logic                last_hw_q;   // 1: last grant went to HW
  logic                owner_hw_q;  // owner of current / most recent op
  logic                op_we_q;
  logic [ADDR_W-1:0]   sram_addr_q;
  logic [DATA_W-1:0]   sram_dq_q;
  logic [DATA_W-1:0]   rd_q;

  logic                reg_wr;
  logic                cpu_busy;
  logic                grant_cpu;
  logic                grant_hw;
  logic                last_access;
  logic                unused_wdata;

  assign unused_wdata = ^writedata[31:DATA_W];

  assign reg_wr      = chipselect & ~write_n;
  // CPU register updates are frozen from start until its op has retired.
  assign cpu_busy    = cpu_pending_q | ((state_q != S_IDLE) & ~owner_hw_q);
  // On a tie the requester that did not win last time gets the bus.
  assign grant_cpu   = (state_q == S_IDLE) & cpu_pending_q & (~hw_req | last_hw_q);
  assign grant_hw    = (state_q == S_IDLE) & hw_req & ~grant_cpu;
  assign last_access = (state_q == S_ACCESS) & (cnt_q == LAST_CNT);

  // State register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE:    if (grant_cpu | grant_hw) state_d = S_SETUP;
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = '0;
      end
      S_ACCESS: begin
        if (last_access) state_d = S_RECOVER;
        else             cnt_d   = cnt_q + 3'd1;
      end
      S_RECOVER: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    sram_ce_n  = (state_q == S_IDLE);
    sram_oe_n  = ~((state_q == S_ACCESS) & ~op_we_q);
    sram_we_n  = ~((state_q == S_ACCESS) &  op_we_q);
    // Data stays driven through RECOVER to give the SRAM write hold time.
    sram_dq_oe = (state_q != S_IDLE) & op_we_q;
    hw_gnt     = grant_hw & reset_n;
    hw_done    = (state_q == S_RECOVER) & owner_hw_q;
  end

  // Registers, arbitration bookkeeping and datapath
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      cpu_pending_q <= 1'b0;
      cpu_we_q      <= 1'b0;
      done_q        <= 1'b0;
      last_hw_q     <= 1'b1;
      owner_hw_q    <= 1'b0;
      op_we_q       <= 1'b0;
      sram_addr_q   <= '0;
      sram_dq_q     <= '0;
      rd_q          <= '0;
    end else begin
      if (reg_wr && !cpu_busy) begin
        unique case (address)
          2'd0: addr_q  <= writedata[ADDR_W-1:0];
          2'd1: wdata_q <= writedata[DATA_W-1:0];
          2'd2: if (writedata[1] | writedata[0]) begin
            cpu_pending_q <= 1'b1;
            cpu_we_q      <= writedata[1];
            done_q        <= 1'b0;
          end
          default: ;
        endcase
      end
      if (reg_wr && address == 2'd2 && writedata[3]) done_q <= 1'b0;

      if (grant_cpu || grant_hw) begin
        owner_hw_q  <= grant_hw;
        last_hw_q   <= grant_hw;
        op_we_q     <= grant_cpu ? cpu_we_q : hw_we;
        sram_addr_q <= grant_cpu ? addr_q   : hw_addr;
        sram_dq_q   <= grant_cpu ? wdata_q  : hw_wdata;
        if (grant_cpu) cpu_pending_q <= 1'b0;
      end

      if (last_access && !op_we_q) rd_q <= sram_dq_in;

      // Completion wins over a same-cycle clear-done.
      if (state_q == S_RECOVER && !owner_hw_q) begin
        done_q <= 1'b1;
        if (!op_we_q) rdata_q <= rd_q;
      end
    end
  end

  assign sram_addr   = sram_addr_q;
  assign sram_dq_out = sram_dq_q;
  assign hw_rdata    = rd_q;

  always_comb begin
    readdata = '0;
    unique case (address)
      2'd0: readdata[ADDR_W-1:0] = addr_q;
      2'd1: readdata[DATA_W-1:0] = wdata_q;
      2'd2: readdata[3:0]        = {done_q, owner_hw_q, (state_q != S_IDLE), cpu_pending_q};
      2'd3: readdata[DATA_W-1:0] = rdata_q;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_system_sram_arbiter.sv
// Bench for nios_system_sram_arbiter: instance 0 uses WAIT_CYCLES=1 and
// instance 1 uses WAIT_CYCLES=0, each with its own SRAM memory. A
// transaction-level model predicts every output on every cycle. Directed
// tests pin the model with hand-computed literals.
module tb_nios_system_sram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n     [2];
  logic [1:0]  address     [2];
  logic        chipselect  [2];
  logic        write_n     [2];
  logic [31:0] writedata   [2];
  logic [31:0] readdata    [2];
  logic        hw_req      [2];
  logic        hw_we       [2];
  logic [10:0] hw_addr     [2];
  logic [15:0] hw_wdata    [2];
  logic        hw_gnt      [2];
  logic        hw_done     [2];
  logic [15:0] hw_rdata    [2];
  logic [10:0] sram_addr   [2];
  logic [15:0] sram_dq_out [2];
  logic        sram_dq_oe  [2];
  logic [15:0] sram_dq_in  [2];
  logic        sram_ce_n   [2];
  logic        sram_oe_n   [2];
  logic        sram_we_n   [2];

  always #5 clk = ~clk;

  nios_system_sram_arbiter #(.ADDR_W(11), .DATA_W(16), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .reset_n(reset_n[0]), .address(address[0]), .chipselect(chipselect[0]),
    .write_n(write_n[0]), .writedata(writedata[0]), .readdata(readdata[0]),
    .hw_req(hw_req[0]), .hw_we(hw_we[0]), .hw_addr(hw_addr[0]), .hw_wdata(hw_wdata[0]),
    .hw_gnt(hw_gnt[0]), .hw_done(hw_done[0]), .hw_rdata(hw_rdata[0]),
    .sram_addr(sram_addr[0]), .sram_dq_out(sram_dq_out[0]), .sram_dq_oe(sram_dq_oe[0]),
    .sram_dq_in(sram_dq_in[0]), .sram_ce_n(sram_ce_n[0]), .sram_oe_n(sram_oe_n[0]),
    .sram_we_n(sram_we_n[0]));

  nios_system_sram_arbiter #(.ADDR_W(11), .DATA_W(16), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset_n(reset_n[1]), .address(address[1]), .chipselect(chipselect[1]),
    .write_n(write_n[1]), .writedata(writedata[1]), .readdata(readdata[1]),
    .hw_req(hw_req[1]), .hw_we(hw_we[1]), .hw_addr(hw_addr[1]), .hw_wdata(hw_wdata[1]),
    .hw_gnt(hw_gnt[1]), .hw_done(hw_done[1]), .hw_rdata(hw_rdata[1]),
    .sram_addr(sram_addr[1]), .sram_dq_out(sram_dq_out[1]), .sram_dq_oe(sram_dq_oe[1]),
    .sram_dq_in(sram_dq_in[1]), .sram_ce_n(sram_ce_n[1]), .sram_oe_n(sram_oe_n[1]),
    .sram_we_n(sram_we_n[1]));

  // SRAM devices: read when selected and output-enabled, write on strobe.
  logic [15:0] dev_mem [2][2048];
  assign sram_dq_in[0] = (!sram_ce_n[0] && !sram_oe_n[0]) ? dev_mem[0][sram_addr[0]] : 16'h0000;
  assign sram_dq_in[1] = (!sram_ce_n[1] && !sram_oe_n[1]) ? dev_mem[1][sram_addr[1]] : 16'h0000;

  always @(posedge clk) begin
    for (int n = 0; n < 2; n++)
      if (!sram_ce_n[n] && !sram_we_n[n]) dev_mem[n][sram_addr[n]] = sram_dq_out[n];
  end

  // Scoreboard counters
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input int n, input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL inst%0d %s: got=%h expected=%h (cycle %0d)", n, name, got, exp, cyc);
    end
  endtask

  // Transaction-level model. m_phase counts cycles since the grant
  // (0 = idle): 1 setup, 2..2+W access, 3+W recover.
  int          m_phase   [2];
  bit          m_pend    [2];
  bit          m_cwe     [2];
  bit          m_last_hw [2];
  bit          m_owner_hw[2];
  bit          m_done    [2];
  bit          m_we      [2];
  logic [10:0] m_ra      [2];
  logic [10:0] m_saddr   [2];
  logic [15:0] m_rw      [2];
  logic [15:0] m_rd      [2];
  logic [15:0] m_sdq     [2];
  logic [15:0] m_mem     [2][2048];

  always @(posedge clk) begin
    cyc++;
    for (int n = 0; n < 2; n++) begin
      int w;
      bit wr, cbusy, gcpu, ghw;
      w = (n == 0) ? 1 : 0;
      if (m_phase[n] == 2 && m_we[n]) m_mem[n][m_saddr[n]] = m_sdq[n];
      if (!reset_n[n]) begin
        m_phase[n] = 0; m_pend[n] = 0; m_cwe[n] = 0; m_last_hw[n] = 1;
        m_owner_hw[n] = 0; m_done[n] = 0; m_we[n] = 0; m_ra[n] = '0;
        m_saddr[n] = '0; m_rw[n] = '0; m_rd[n] = '0; m_sdq[n] = '0;
      end else begin
        wr    = chipselect[n] && !write_n[n];
        cbusy = m_pend[n] || (m_phase[n] != 0 && !m_owner_hw[n]);
        gcpu  = (m_phase[n] == 0) && m_pend[n] && (!hw_req[n] || m_last_hw[n]);
        ghw   = (m_phase[n] == 0) && hw_req[n] && !gcpu;
        if (wr && !cbusy) begin
          if (address[n] == 2'd0) m_ra[n] = writedata[n][10:0];
          if (address[n] == 2'd1) m_rw[n] = writedata[n][15:0];
          if (address[n] == 2'd2 && (writedata[n][0] || writedata[n][1])) begin
            m_pend[n] = 1; m_cwe[n] = writedata[n][1]; m_done[n] = 0;
          end
        end
        if (wr && address[n] == 2'd2 && writedata[n][3]) m_done[n] = 0;
        if (gcpu || ghw) begin
          m_phase[n]    = 1;
          m_owner_hw[n] = ghw;
          m_last_hw[n]  = ghw;
          m_we[n]       = gcpu ? m_cwe[n] : hw_we[n];
          m_saddr[n]    = gcpu ? m_ra[n]  : hw_addr[n];
          m_sdq[n]      = gcpu ? m_rw[n]  : hw_wdata[n];
          if (gcpu) m_pend[n] = 0;
        end else if (m_phase[n] == 3 + w) begin
          if (!m_owner_hw[n]) begin
            m_done[n] = 1;
            if (!m_we[n]) m_rd[n] = m_mem[n][m_saddr[n]];
          end
          m_phase[n] = 0;
        end else if (m_phase[n] != 0) begin
          m_phase[n]++;
        end
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      for (int n = 0; n < 2; n++) begin
        int w, ph;
        bit acc, e_gnt;
        logic [31:0] e_rd;
        w     = (n == 0) ? 1 : 0;
        ph    = m_phase[n];
        acc   = (ph >= 2) && (ph <= 2 + w);
        e_gnt = reset_n[n] && ph == 0 && hw_req[n] && !(m_pend[n] && (!hw_req[n] || m_last_hw[n]));
        case (address[n])
          2'd0:    e_rd = {21'b0, m_ra[n]};
          2'd1:    e_rd = {16'b0, m_rw[n]};
          2'd2:    e_rd = {28'b0, m_done[n], m_owner_hw[n], (ph != 0), m_pend[n]};
          default: e_rd = {16'b0, m_rd[n]};
        endcase
        chk(n, "ce_n",     32'(sram_ce_n[n]),  32'(ph == 0));
        chk(n, "oe_n",     32'(sram_oe_n[n]),  32'(!(acc && !m_we[n])));
        chk(n, "we_n",     32'(sram_we_n[n]),  32'(!(acc && m_we[n])));
        chk(n, "dq_oe",    32'(sram_dq_oe[n]), 32'(ph != 0 && m_we[n]));
        chk(n, "sram_addr", 32'(sram_addr[n]), 32'(m_saddr[n]));
        chk(n, "hw_gnt",   32'(hw_gnt[n]),     32'(e_gnt));
        chk(n, "hw_done",  32'(hw_done[n]),    32'(ph == 3 + w && m_owner_hw[n]));
        chk(n, "readdata", readdata[n],        e_rd);
        chk(n, "oe_we_excl", 32'(sram_oe_n[n] | sram_we_n[n]), 32'(1));
        if (ph != 0 && m_we[n]) chk(n, "dq_out", 32'(sram_dq_out[n]), 32'(m_sdq[n]));
        if (ph == 3 + w && m_owner_hw[n] && !m_we[n])
          chk(n, "hw_rdata", 32'(hw_rdata[n]), 32'(m_mem[n][m_saddr[n]]));
      end
    end
  end

  // Stimulus helpers: inputs change 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input int n, input logic [1:0] a, input logic [31:0] d);
    address[n] = a; writedata[n] = d; chipselect[n] = 1'b1; write_n[n] = 1'b0;
    tick();
    chipselect[n] = 1'b0; write_n[n] = 1'b1;
  endtask

  task automatic rd(input int n, input logic [1:0] a, output logic [31:0] v);
    address[n] = a;
    @(negedge clk);
    v = readdata[n];
    tick();
  endtask

  task automatic wait_gnt(input int n, output int at);
    at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (hw_gnt[n] === 1'b1) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL inst%0d gnt_wait: no hw_gnt within 40 cycles (cycle %0d)", n, cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int t, g0, cnt;
    for (int n = 0; n < 2; n++) begin
      reset_n[n] = 1'b0; address[n] = 2'd0; chipselect[n] = 1'b0; write_n[n] = 1'b1;
      writedata[n] = '0; hw_req[n] = 1'b0; hw_we[n] = 1'b0; hw_addr[n] = '0; hw_wdata[n] = '0;
      m_phase[n] = 0;
    end
    for (int i = 0; i < 2048; i++) begin
      logic [15:0] pv;
      pv = 16'(i) ^ 16'hA5A5;
      dev_mem[0][i] = pv; dev_mem[1][i] = pv; m_mem[0][i] = pv; m_mem[1][i] = pv;
    end
    repeat (3) tick();
    reset_n[0] = 1'b1; reset_n[1] = 1'b1;
    chk_en = 1'b1;

    // Reset state
    address[0] = 2'd2;
    @(negedge clk);
    chk(0, "rst_status", readdata[0], 32'h0);
    chk(0, "rst_ce_n", 32'(sram_ce_n[0]), 32'h1);
    chk(0, "rst_sram_addr", 32'(sram_addr[0]), 32'h0);
    tick();

    // 1. CPU write then read
    cpu_wr(0, 2'd0, 32'h155);
    cpu_wr(0, 2'd1, 32'hBEEF);
    cpu_wr(0, 2'd2, 32'h2);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!sram_we_n[0] && sram_dq_oe[0] && sram_addr[0] == 11'h155) cnt++;
      tick();
    end
    chk(0, "t1_we_cycles", 32'(cnt), 32'd2);
    cpu_wr(0, 2'd2, 32'h1);
    repeat (8) tick();
    rd(0, 2'd3, v); chk(0, "t1_rdata", v, 32'h0000BEEF);
    rd(0, 2'd2, v); chk(0, "t1_status", v, 32'h8);

    // 2. HW read of the top address
    hw_req[0] = 1'b1; hw_we[0] = 1'b0; hw_addr[0] = 11'h7FF;
    wait_gnt(0, t);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) hw_req[0] = 1'b0;
      @(negedge clk);
      chk(0, "t2_oe_n", 32'(sram_oe_n[0]), 32'(!(k == 2 || k == 3)));
      chk(0, "t2_done", 32'(hw_done[0]), 32'(k == 4));
      if (k == 4) chk(0, "t2_rdata", 32'(hw_rdata[0]), 32'hA25A);
      if (k == 5) chk(0, "t2_ce_n", 32'(sram_ce_n[0]), 32'h1);
    end
    tick();

    // 3. Simultaneous CPU start and hw_req from reset
    reset_n[0] = 1'b0; tick(); tick(); reset_n[0] = 1'b1;
    cpu_wr(0, 2'd2, 32'h1);
    hw_req[0] = 1'b1; hw_we[0] = 1'b0; hw_addr[0] = 11'h020;
    g0 = cyc;
    rd(0, 2'd2, v); chk(0, "t3_grant_status", v, 32'h1);
    rd(0, 2'd2, v); chk(0, "t3_cpu_owner", v, 32'h2);
    wait_gnt(0, t);
    chk(0, "t3_hw_gnt_cycle", 32'(t - g0), 32'd5);
    tick(); hw_req[0] = 1'b0;
    repeat (6) tick();
    cpu_wr(0, 2'd2, 32'h1);
    repeat (7) tick();
    cpu_wr(0, 2'd2, 32'h1);
    hw_req[0] = 1'b1; hw_addr[0] = 11'h010;
    @(negedge clk);
    chk(0, "t3_tie_hw_wins", 32'(hw_gnt[0]), 32'h1);
    tick(); hw_req[0] = 1'b0;
    rd(0, 2'd2, v); chk(0, "t3_tie_status", v, 32'h7);
    repeat (12) tick();

    // 4. CPU register writes while its op is in flight
    cpu_wr(0, 2'd0, 32'h0AA);
    cpu_wr(0, 2'd2, 32'h1);
    cpu_wr(0, 2'd0, 32'h001);
    cpu_wr(0, 2'd2, 32'h1);
    rd(0, 2'd0, v); chk(0, "t4_addr_kept", v, 32'h0AA);
    rd(0, 2'd2, v); chk(0, "t4_busy_status", v, 32'h2);
    repeat (8) tick();
    rd(0, 2'd2, v); chk(0, "t4_final_status", v, 32'h8);
    rd(0, 2'd3, v); chk(0, "t4_rdata", v, 32'h0000A50F);

    // 5. Reset during a HW write ACCESS
    hw_req[0] = 1'b1; hw_we[0] = 1'b1; hw_addr[0] = 11'h03C; hw_wdata[0] = 16'h1357;
    wait_gnt(0, t);
    tick(); hw_req[0] = 1'b0;
    tick();
    reset_n[0] = 1'b0;
    tick();
    reset_n[0] = 1'b1;
    address[0] = 2'd2;
    @(negedge clk);
    chk(0, "t5_ce_n", 32'(sram_ce_n[0]), 32'h1);
    chk(0, "t5_we_n", 32'(sram_we_n[0]), 32'h1);
    chk(0, "t5_dq_oe", 32'(sram_dq_oe[0]), 32'h0);
    chk(0, "t5_status", readdata[0], 32'h0);
    chk(0, "t5_hw_rdata", 32'(hw_rdata[0]), 32'h0);
    chk(0, "t5_sram_addr", 32'(sram_addr[0]), 32'h0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      if (hw_done[0]) cnt++;
    end
    chk(0, "t5_no_done", 32'(cnt), 32'd0);
    tick();

    // 6. WAIT_CYCLES=0 instance
    cpu_wr(1, 2'd0, 32'h02A);
    cpu_wr(1, 2'd1, 32'h55AA);
    cpu_wr(1, 2'd2, 32'h2);
    address[1] = 2'd2;
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      chk(1, "t6_done_timing", 32'(readdata[1][3]), 32'(k == 4));
      tick();
    end
    hw_req[1] = 1'b1; hw_we[1] = 1'b0; hw_addr[1] = 11'h02A;
    wait_gnt(1, t);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) hw_req[1] = 1'b0;
      @(negedge clk);
      chk(1, "t6_hw_done", 32'(hw_done[1]), 32'(k == 3));
      if (k == 3) chk(1, "t6_hw_rdata", 32'(hw_rdata[1]), 32'h55AA);
    end
    tick();
    rd(1, 2'd2, v); chk(1, "t6_status_done", v, 32'hC);
    cpu_wr(1, 2'd2, 32'h8);
    rd(1, 2'd2, v); chk(1, "t6_status_cleared", v, 32'h4);

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
